// File: rtl/sa_pkg.sv
// sa_pkg: shared types and constants for the systolic-array host interface.
// Holds the FSM state encoding, address region codes and the bit positions
// of the control and status words.
package sa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sa_state_e;

  // Address region (top two address bits)
  localparam logic [1:0] RGN_WGT = 2'b00;
  localparam logic [1:0] RGN_ACT = 2'b01;
  localparam logic [1:0] RGN_RES = 2'b10;
  localparam logic [1:0] RGN_CTL = 2'b11;

  // Status word bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_OVF  = 3;
  localparam int STAT_W    = 4;

  // Control word bit positions
  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;

endpackage

// File: rtl/sa_res_buf.sv
// sa_res_buf: one result column buffer. Results are appended in arrival
// order; the fill count doubles as the "rows valid" bound for reads.
// Buffer storage is never reset; only the pointer and fill count are.
module sa_res_buf
  import sa_pkg::*;
#(
  parameter int MAC_W  = 19,
  parameter int DEPTH  = 8,
  parameter int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              wr_vi,
  input  logic [MAC_W-1:0]  wdata_i,
  input  logic [FILL_W-1:0] rd_row_i,
  output logic [MAC_W-1:0]  rd_data_o,
  output logic              drop_o,
  output logic              full_nxt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [MAC_W-1:0]  r_mem [DEPTH];
  logic [FILL_W-1:0] r_fill;
  logic [PTR_W-1:0]  r_wptr;
  logic              w_full;
  logic              w_acc;

  assign w_full     = (r_fill == FILL_W'(DEPTH));
  assign w_acc      = wr_vi & en_i & ~w_full;
  assign drop_o     = wr_vi & ~w_acc;
  assign full_nxt_o = w_full | (w_acc & (r_fill == FILL_W'(DEPTH - 1)));
  assign rd_data_o  = (rd_row_i < r_fill) ? r_mem[rd_row_i[PTR_W-1:0]] : '0;

  // Write pointer and fill count: cleared on reset or run start
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_fill <= '0;
      r_wptr <= '0;
    end else if (w_acc) begin
      r_fill <= r_fill + FILL_W'(1);
      r_wptr <= r_wptr + PTR_W'(1);
    end
  end

  // Result storage: append accepted results
  always_ff @(posedge clk_i) begin
    if (w_acc) r_mem[r_wptr] <= wdata_i;
  end

endmodule

// File: rtl/sa_host_if.sv
// sa_host_if: host register interface for a systolic array. Passes weight
// and activation writes straight through to the array, starts runs,
// collects per-column results and serves status/result reads.
// Optional feature: define SA_CYCLE_CNT_EN to compile in the run-cycle counter.
module sa_host_if
  import sa_pkg::*;
#(
  parameter int X_W     = 8,
  parameter int MAC_W   = 19,
  parameter int ARRAY_W = 8,
  parameter int ARRAY_H = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(ARRAY_W * ARRAY_H),
  localparam int ADDR_W = IDX_W + 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [X_W-1:0]           wdata_i,
  input  logic                     wr_vi,
  input  logic                     rd_vi,
  output logic [MAC_W-1:0]         rdata_o,
  output logic                     rdata_vo,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [X_W-1:0]           w_o,
  output logic [IDX_W-1:0]         w_addr_o,
  output logic                     w_en_o,
  output logic [X_W-1:0]           rbuf_wdata_o,
  output logic [IDX_W-1:0]         rbuf_waddr_o,
  output logic                     rbuf_w_vo,
  output logic                     start_vo,
  input  logic [ARRAY_W*MAC_W-1:0] mac_i,
  input  logic [ARRAY_W-1:0]       mac_vi
);

  localparam int FILL_W = $clog2(ARRAY_H + 1);

  sa_state_e          r_state;
  sa_state_e          w_state_nxt;
  logic               r_err;
  logic               r_ovf;
  logic               r_start_vo;
  logic               r_rdata_vo;
  logic [MAC_W-1:0]   r_rdata;

  logic [1:0]         w_rgn;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_col;
  logic [FILL_W-1:0]  w_row;
  logic               w_idx_ok;
  logic               w_run;
  logic               w_ctl_wr;
  logic               w_start_req;
  logic               w_clr_req;
  logic               w_start_ok;
  logic               w_err_set;
  logic [ARRAY_W-1:0] w_drop;
  logic [ARRAY_W-1:0] w_full_nxt;
  logic [MAC_W-1:0]   w_col_rd [ARRAY_W];
  logic [STAT_W-1:0]  w_status;
  logic [MAC_W-1:0]   w_rd_mux;
  logic [CNT_W-1:0]   w_cyc_cnt;

  assign w_rgn    = addr_i[ADDR_W-1 -: 2];
  assign w_idx    = addr_i[IDX_W-1:0];
  assign w_col    = IDX_W'(w_idx / ARRAY_H);
  assign w_row    = FILL_W'(w_idx % ARRAY_H);
  assign w_idx_ok = (32'(w_idx) < ARRAY_W * ARRAY_H);
  assign w_run    = (r_state == S_RUN);

  assign w_ctl_wr    = wr_vi && (w_rgn == RGN_CTL) && (w_idx == '0);
  assign w_clr_req   = w_ctl_wr & wdata_i[CTRL_CLR];
  assign w_start_req = w_ctl_wr & wdata_i[CTRL_START];

  // Load paths are pure pass-through; only the strobes are gated
  assign w_o          = wdata_i;
  assign w_addr_o     = w_idx;
  assign rbuf_wdata_o = wdata_i;
  assign rbuf_waddr_o = w_idx;

  assign busy_o   = w_run;
  assign done_o   = (r_state == S_DONE);
  assign start_vo = r_start_vo;
  assign rdata_o  = r_rdata;
  assign rdata_vo = r_rdata_vo;

  for (genvar c = 0; c < ARRAY_W; c++) begin : g_col
    sa_res_buf #(
      .MAC_W  (MAC_W),
      .DEPTH  (ARRAY_H),
      .FILL_W (FILL_W)
    ) u_buf (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (w_start_ok),
      .en_i       (w_run),
      .wr_vi      (mac_vi[c]),
      .wdata_i    (mac_i[c*MAC_W +: MAC_W]),
      .rd_row_i   (w_row),
      .rd_data_o  (w_col_rd[c]),
      .drop_o     (w_drop[c]),
      .full_nxt_o (w_full_nxt[c])
    );
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state, load strobes and error detection
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_err_set   = 1'b0;
    w_en_o      = 1'b0;
    rbuf_w_vo   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_en_o    = wr_vi && (w_rgn == RGN_WGT) && !rst_i;
        rbuf_w_vo = wr_vi && (w_rgn == RGN_ACT) && !rst_i;
        if (w_start_req) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_RUN;
        end else if (w_clr_req && (r_state == S_DONE)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (wr_vi && ((w_rgn == RGN_WGT) || (w_rgn == RGN_ACT))) w_err_set = 1'b1;
        if (w_start_req) w_err_set = 1'b1;
        if (&w_full_nxt) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sticky flags and the start pulse; clear acts before any same-cycle set
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_start_vo <= 1'b0;
    end else begin
      r_err      <= (r_err & ~w_clr_req) | w_err_set;
      r_ovf      <= (r_ovf & ~(w_clr_req | w_start_ok)) | (|w_drop);
      r_start_vo <= w_start_ok;
    end
  end

`ifdef SA_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_cyc_cnt;

  // Run-cycle counter: restarts on start, saturates, holds outside RUN
  always_ff @(posedge clk_i) begin
    if (rst_i || w_start_ok)          r_cyc_cnt <= '0;
    else if (w_run && ~&r_cyc_cnt)    r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
  end

  assign w_cyc_cnt = r_cyc_cnt;
`else
  assign w_cyc_cnt = '0;
`endif

  // Status word assembly
  always_comb begin
    w_status            = '0;
    w_status[STAT_BUSY] = w_run;
    w_status[STAT_DONE] = (r_state == S_DONE);
    w_status[STAT_ERR]  = r_err;
    w_status[STAT_OVF]  = r_ovf;
  end

  // Read mux over pre-write register contents
  always_comb begin
    w_rd_mux = '0;
    case (w_rgn)
      RGN_RES: begin
        if (w_idx_ok) begin
          for (int c = 0; c < ARRAY_W; c++) begin
            if (w_col == IDX_W'(c)) w_rd_mux = w_col_rd[c];
          end
        end
      end
      RGN_CTL: begin
        if (w_idx == '0)              w_rd_mux = MAC_W'(w_status);
        else if (w_idx == IDX_W'(1))  w_rd_mux = MAC_W'(w_cyc_cnt);
      end
      default: w_rd_mux = '0;
    endcase
  end

  // Registered read response, one cycle after the strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata_vo <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rdata_vo <= rd_vi;
      if (rd_vi) r_rdata <= w_rd_mux;
    end
  end

endmodule

// File: tb/tb_sa_host_if.sv
// tb_sa_host_if: directed + randomized bench for sa_host_if with a
// transaction-level reference model of the register map and result store.
module tb_sa_host_if;

  localparam int X_W   = 8;
  localparam int MAC_W = 19;
  localparam int AW    = 8;
  localparam int AH    = 8;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [7:0]           addr = '0;
  logic [X_W-1:0]       wdata = '0;
  logic                 wr = 1'b0;
  logic                 rd = 1'b0;
  logic [MAC_W-1:0]     rdata;
  logic                 rdata_v;
  logic                 busy;
  logic                 done;
  logic [X_W-1:0]       w_o;
  logic [5:0]           w_addr;
  logic                 w_en;
  logic [X_W-1:0]       rb_wdata;
  logic [5:0]           rb_waddr;
  logic                 rb_wv;
  logic                 start_v;
  logic [AW*MAC_W-1:0]  mac = '0;
  logic [AW-1:0]        mac_v = '0;

  sa_host_if #(
    .X_W(X_W), .MAC_W(MAC_W), .ARRAY_W(AW), .ARRAY_H(AH), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata), .wr_vi(wr), .rd_vi(rd),
    .rdata_o(rdata), .rdata_vo(rdata_v), .busy_o(busy), .done_o(done),
    .w_o(w_o), .w_addr_o(w_addr), .w_en_o(w_en),
    .rbuf_wdata_o(rb_wdata), .rbuf_waddr_o(rb_waddr), .rbuf_w_vo(rb_wv),
    .start_vo(start_v), .mac_i(mac), .mac_vi(mac_v)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 run, 2 done
  int               m_state;
  int               m_fill [AW];
  logic [MAC_W-1:0] m_buf  [AW][AH];
  bit               m_err, m_ovf, m_start;
  int               m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAC_W-1:0] m_read(input logic [7:0] a);
    int idx, col, row;
    idx = int'(a[5:0]);
    col = idx / AH;
    row = idx % AH;
    case (a[7:6])
      2'b10: return (row < m_fill[col]) ? m_buf[col][row] : '0;
      2'b11: begin
        if (idx == 0) return MAC_W'({m_ovf, m_err, (m_state == 2), (m_state == 1)});
`ifdef SA_CYCLE_CNT_EN
        if (idx == 1) return MAC_W'(m_cnt);
`endif
        return '0;
      end
      default: return '0;
    endcase
  endfunction

  // One clock: check load strobes, advance the model, check registered outputs
  task automatic tick();
    logic [MAC_W-1:0] rexp;
    bit rdq, wgt_ok, act_ok, go, all_full;
    int ps;
    #1;
    wgt_ok = wr && (addr[7:6] == 2'b00) && (m_state != 1) && !rst;
    act_ok = wr && (addr[7:6] == 2'b01) && (m_state != 1) && !rst;
    chk("w_en_o", w_en, wgt_ok);
    chk("rbuf_w_vo", rb_wv, act_ok);
    if (wgt_ok) begin chk("w_addr_o", w_addr, addr[5:0]); chk("w_o", w_o, wdata); end
    if (act_ok) begin chk("rbuf_waddr_o", rb_waddr, addr[5:0]); chk("rbuf_wdata_o", rb_wdata, wdata); end
    rexp = m_read(addr);
    rdq  = rd && !rst;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_err = 0; m_ovf = 0; m_cnt = 0; m_start = 0;
      for (int c = 0; c < AW; c++) m_fill[c] = 0;
    end else begin
      ps = m_state; go = 0; m_start = 0;
      if (wr && addr == 8'hC0) begin
        if (wdata[1]) begin m_err = 0; m_ovf = 0; if (m_state == 2) m_state = 0; end
        if (wdata[0]) begin if (ps != 1) go = 1; else m_err = 1; end
      end
      if (wr && !addr[7] && ps == 1) m_err = 1;
      for (int c = 0; c < AW; c++) begin
        if (mac_v[c]) begin
          if (ps == 1 && m_fill[c] < AH) begin
            m_buf[c][m_fill[c]] = mac[c*MAC_W +: MAC_W];
            m_fill[c]++;
          end else m_ovf = 1;
        end
      end
      if (ps == 1 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (ps == 1) begin
        all_full = 1;
        for (int c = 0; c < AW; c++) if (m_fill[c] != AH) all_full = 0;
        if (all_full) m_state = 2;
      end
      if (go) begin
        for (int c = 0; c < AW; c++) m_fill[c] = 0;
        m_ovf = 0; m_cnt = 0; m_state = 1; m_start = 1;
      end
    end
    #1;
    chk("rdata_vo", rdata_v, rdq);
    if (rdq) chk("rdata_o", rdata, rexp);
    if (rst) chk("rdata_o_rst", rdata, 0);
    chk("busy_o", busy, (m_state == 1));
    chk("done_o", done, (m_state == 2));
    chk("start_vo", start_v, m_start);
    wr = 0; rd = 0; mac_v = '0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [X_W-1:0] d);
    addr = a; wdata = d; wr = 1; tick();
  endtask

  task automatic rd_reg(input logic [7:0] a);
    addr = a; rd = 1; tick();
  endtask

  task automatic mac_row(input int r);
    for (int c = 0; c < AW; c++) mac[c*MAC_W +: MAC_W] = MAC_W'(100 * c + r);
    mac_v = '1; tick();
  endtask

  initial begin
    int exp_cnt;
    // Reset
    rst = 1; tick(); tick();
    rst = 0;
    chk("status_rst_busy", busy, 0);
    rd_reg(8'hC0); chk("status_after_reset", rdata, 0);

    // Weight/activation pass-through in IDLE
    wr_reg(8'h05, 8'h3C);
    addr = 8'h49; wdata = 8'hA5; wr = 1; tick();

    // Start, then write while running
    wr_reg(8'hC0, 8'h01);
    wr_reg(8'h05, 8'h3C);
    rd_reg(8'hC0); chk("status_run_err", rdata, 19'h5);
    wr_reg(8'hC0, 8'h02);
    rd_reg(8'hC0); chk("status_run_clr", rdata, 19'h1);

    // Fill all columns with 100*c+r
    for (int r = 0; r < AH; r++) mac_row(r);
    chk("done_after_last", done, 1);
    rd_reg(8'h9A); chk("res_c3_r2", rdata, 302);

    // Overflow after DONE, then clear with a simultaneous status read
    mac[MAC_W-1:0] = 19'h1234; mac_v = 8'h01; tick();
    rd_reg(8'hC0); chk("status_done_ovf", rdata, 19'h0A);
    addr = 8'hC0; wdata = 8'h02; wr = 1; rd = 1; tick();
    chk("rd_pre_write", rdata, 19'h0A);
    rd_reg(8'hC0); chk("status_cleared", rdata, 0);

    // Start during RUN
    wr_reg(8'hC0, 8'h01);
    wr_reg(8'hC0, 8'h01); chk("no_second_start", start_v, 0);
    for (int r = 0; r < AH; r++) mac_row(r);
    rd_reg(8'hC0); chk("status_done_err", rdata, 19'h6);
    wr_reg(8'hC0, 8'h02);
    rd_reg(8'hC0); chk("status_idle", rdata, 0);
    chk("idle_not_done", done, 0);

    // Randomized fill with interleaved reads
    wr_reg(8'hC0, 8'h01);
    for (int k = 0; k < 400 && m_state != 2; k++) begin
      logic [AW-1:0] mv;
      mv = AW'($urandom);
      for (int c = 0; c < AW; c++) begin
        if (m_fill[c] >= AH) mv[c] = 1'b0;
        mac[c*MAC_W +: MAC_W] = MAC_W'($urandom);
      end
      mac_v = mv;
      if ($urandom_range(0, 2) == 0) begin
        rd = 1;
        addr = ($urandom_range(0, 3) == 0) ? 8'hC0 : {2'b10, 6'($urandom)};
      end
      tick();
    end
    chk("rand_run_done", done, 1);
    for (int i = 0; i < AW * AH; i++) rd_reg({2'b10, 6'(i)});
    rd_reg(8'hC0); chk("rand_status", rdata, 19'h2);
    wr_reg(8'hC0, 8'h02);

    // Reset mid-run; load strobe suppressed during reset
    wr_reg(8'hC0, 8'h01);
    mac_row(0); mac_row(1); mac_row(2);
    rst = 1; addr = 8'h05; wdata = 8'h11; wr = 1; rd = 1; tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata_vo", rdata_v, 0);
    rd_reg(8'h80); chk("rst_fill_cleared", rdata, 0);

    // Run lasting exactly 20 cycles, then read the cycle counter
    wr_reg(8'hC0, 8'h01);
    for (int k = 0; k < 12; k++) tick();
    for (int r = 0; r < AH; r++) mac_row(r);
    chk("run20_done", done, 1);
`ifdef SA_CYCLE_CNT_EN
    exp_cnt = 20;
`else
    exp_cnt = 0;
`endif
    rd_reg(8'hC1); chk("cycle_count", rdata, exp_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
